// File: rtl/aes_dec_sched.sv
// aes_dec_sched: two-requester job scheduler in front of an AES-128 inverse
// cipher core. Jobs are granted round-robin, the key is loaded into the core
// and given KEY_WAIT cycles to expand, then the ciphertext is loaded and the
// plaintext is returned on the rsp_* handshake.
//
// Optional feature: define AES_DEC_KEY_CACHE_EN to remember the last key loaded
// into the core. A job with the same key then skips the key load and wait.
// Without the macro every job reloads its key.
//
// state | meaning
// IDLE  | no job in flight, round-robin arbitration between req0 and req1
// KLOAD | one-cycle core_kld strobe, core starts its key expansion
// KWAIT | KEY_WAIT cycles for the key expansion to finish
// LOAD  | one-cycle core_ld strobe, ciphertext handed to the core
// RUN   | waiting for core_done, plaintext captured on that cycle
// RESP  | plaintext offered on rsp_*, held until rsp_ready
module aes_dec_sched #(
    parameter int unsigned KEY_WAIT = 14
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_text,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_text,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [127:0] rsp_text,

    output logic         core_kld,
    output logic         core_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text_in,
    input  logic         core_done,
    input  logic [127:0] core_text_out,

    output logic         busy
);

    // Down-counter preload: KWAIT ends on the cycle the counter reads zero,
    // so loading KEY_WAIT-1 gives exactly KEY_WAIT cycles in KWAIT.
    localparam logic [7:0] WAIT_LOAD = 8'(KEY_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        KWAIT = 3'd2,
        LOAD  = 3'd3,
        RUN   = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t         state;
    logic [7:0]     wait_cnt;
    logic           last_served;
    logic [127:0]   key_q;
    logic [127:0]   text_q;

    logic           grant1;
    logic           take;
    logic [127:0]   sel_key;
    logic [127:0]   sel_text;
    logic           key_hit;

    // The core sees the captured job registers directly; they only change on a handshake.
    assign core_key     = key_q;
    assign core_text_in = text_q;

    // Round-robin grant and request selection while idle
    always_comb begin
        grant1     = req1_valid && (!req0_valid || !last_served);
        take       = (state == IDLE) && (req0_valid || req1_valid);
        req0_ready = (state == IDLE) && req0_valid && !grant1;
        req1_ready = (state == IDLE) && grant1;
        sel_key    = grant1 ? req1_key  : req0_key;
        sel_text   = grant1 ? req1_text : req0_text;
    end

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_vld;

    // Remember the key most recently expanded by the core
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_key <= '0;
            cache_vld <= 1'b0;
        end else if (state == KLOAD) begin
            cache_key <= key_q;
            cache_vld <= 1'b1;
        end
    end

    assign key_hit = cache_vld && (sel_key == cache_key);
`else
    assign key_hit = 1'b0;
`endif

    // Job sequencing FSM with registered strobes and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= 8'd0;
            last_served <= 1'b1;
            key_q       <= '0;
            text_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_text    <= '0;
            core_kld    <= 1'b0;
            core_ld     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            core_kld <= 1'b0;
            core_ld  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        key_q       <= sel_key;
                        text_q      <= sel_text;
                        last_served <= grant1;
                        busy        <= 1'b1;
                        if (key_hit) begin
                            state   <= LOAD;
                            core_ld <= 1'b1;
                        end else begin
                            state    <= KLOAD;
                            core_kld <= 1'b1;
                        end
                    end
                end
                KLOAD: begin
                    state    <= KWAIT;
                    wait_cnt <= WAIT_LOAD;
                end
                KWAIT: begin
                    if (wait_cnt == 8'd0) begin
                        state   <= LOAD;
                        core_ld <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    if (core_done) begin
                        state     <= RESP;
                        rsp_text  <= core_text_out;
                        rsp_id    <= last_served;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
